grayscale_line_scheduler: RTL and testbench

//  Sequences one grayscale job between the CCI-P request path and the grayscale datapath.

---
 rtl/grayscale_line_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_grayscale_line_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : grayscale_line_scheduler
// Brief    : Sequences one grayscale job: CCI-P line reads, datapath in-flight
//            cap, write-back to the same line index, write-ack completion.
//            Define GRAYSCALE_SCHED_PERF_EN to add perf_cycles/perf_stalls.
// Revision : 1.0
// ============================================================================
module grayscale_line_scheduler #(
    parameter int ADDR_W          = 42,
    parameter int LINE_CNT_W      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TAG_W           = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LINE_CNT_W-1:0] num_lines,
    input  logic [ADDR_W-1:0]     rd_base,
    input  logic [ADDR_W-1:0]     wr_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  c0_almfull,
    output logic                  rd_req_valid,
    output logic [ADDR_W-1:0]     rd_req_addr,
    output logic [TAG_W-1:0]      rd_req_tag,
    input  logic                  c1_almfull,
    input  logic                  dp_valid_out,
    output logic                  wr_req_valid,
    output logic [ADDR_W-1:0]     wr_req_addr,
    output logic [TAG_W-1:0]      wr_req_tag,
`ifdef GRAYSCALE_SCHED_PERF_EN
    input  logic                  wr_rsp_valid,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stalls
`else
    input  logic                  wr_rsp_valid
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LINE_CNT_W-1:0] c_max_out = LINE_CNT_W'(MAX_OUTSTANDING);
    localparam logic [LINE_CNT_W-1:0] c_one     = LINE_CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LINE_CNT_W-1:0] r_num_lines;
    logic [ADDR_W-1:0]     r_rd_base;
    logic [ADDR_W-1:0]     r_wr_base;
    logic [LINE_CNT_W-1:0] r_rd_idx;
    logic [LINE_CNT_W-1:0] r_wr_idx;
    logic [LINE_CNT_W-1:0] r_ack_cnt;
    logic                  r_rd_valid;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [TAG_W-1:0]      r_rd_tag;
    logic                  r_wr_valid;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [TAG_W-1:0]      r_wr_tag;
    logic                  r_err;

    logic                  w_start_ok;
    logic [LINE_CNT_W-1:0] w_inflight;
    logic                  w_reads_left;
    logic                  w_cap_ok;
    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_ack_ok;
    logic                  w_err_evt;

    assign w_start_ok   = start && (r_state == S_IDLE);
    assign w_inflight   = r_rd_idx - r_wr_idx;
    assign w_reads_left = r_rd_idx < r_num_lines;
    assign w_cap_ok     = w_inflight < c_max_out;
    // c1_almfull also blocks reads: with the in-flight cap this bounds the
    // writes that can still land after c1 almost-full asserts.
    assign w_rd_fire    = (r_state == S_RUN) && !c0_almfull && !c1_almfull
                          && w_reads_left && w_cap_ok;
    // Datapath results cannot be stalled; an orphan result is flagged, not written.
    assign w_wr_fire    = dp_valid_out && (w_inflight != '0);
    assign w_ack_ok     = wr_rsp_valid && (r_state != S_IDLE) && (r_ack_cnt != r_wr_idx);
    assign w_err_evt    = (dp_valid_out && (w_inflight == '0))
                          || (wr_rsp_valid && ((r_state == S_IDLE) || (r_ack_cnt == r_wr_idx)));

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_lines == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_rd_idx == r_num_lines) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_ack_cnt == r_num_lines) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_num_lines <= '0;
            r_rd_base   <= '0;
            r_wr_base   <= '0;
            r_rd_idx    <= '0;
            r_wr_idx    <= '0;
            r_ack_cnt   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_tag    <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_tag    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_num_lines <= num_lines;
                r_rd_base   <= rd_base;
                r_wr_base   <= wr_base;
                r_rd_idx    <= '0;
                r_wr_idx    <= '0;
                r_ack_cnt   <= '0;
            end else begin
                if (w_rd_fire) r_rd_idx  <= r_rd_idx + c_one;
                if (w_wr_fire) r_wr_idx  <= r_wr_idx + c_one;
                if (w_ack_ok)  r_ack_cnt <= r_ack_cnt + c_one;
            end
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_addr <= r_rd_base + ADDR_W'(r_rd_idx);
                r_rd_tag  <= TAG_W'(r_rd_idx);
            end
            r_wr_valid <= w_wr_fire;
            if (w_wr_fire) begin
                r_wr_addr <= r_wr_base + ADDR_W'(r_wr_idx);
                r_wr_tag  <= TAG_W'(r_wr_idx);
            end
            r_err <= (r_err && !w_start_ok) || w_err_evt;
        end
    end

    assign rd_req_valid = r_rd_valid;
    assign rd_req_addr  = r_rd_addr;
    assign rd_req_tag   = r_rd_tag;
    assign wr_req_valid = r_wr_valid;
    assign wr_req_addr  = r_wr_addr;
    assign wr_req_tag   = r_wr_tag;
    assign err          = r_err;

`ifdef GRAYSCALE_SCHED_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;
    logic        w_stall;

    assign w_stall = (r_state == S_RUN) && w_reads_left
                     && (c0_almfull || c1_almfull || !w_cap_ok);

    // Saturating counters; they stop naturally once busy drops after done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (w_start_ok) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (busy && (r_perf_cycles != '1))    r_perf_cycles <= r_perf_cycles + 32'd1;
            if (w_stall && (r_perf_stalls != '1)) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grayscale_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_grayscale_line_scheduler
// Brief    : Scoreboard bench: expected read/write streams queued per job,
//            monitor compares every request the scheduler presents.
// Revision : 1.0
// ============================================================================
module tb_grayscale_line_scheduler;

    localparam int ADDR_W = 42;
    localparam int LCW    = 32;
    localparam int MAXO   = 8;
    localparam int TAG_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [LCW-1:0]    num_lines = '0;
    logic [ADDR_W-1:0] rd_base = '0;
    logic [ADDR_W-1:0] wr_base = '0;
    logic              busy, done, err;
    logic              c0_almfull = 1'b0;
    logic              c1_almfull = 1'b0;
    logic              rd_req_valid, wr_req_valid;
    logic [ADDR_W-1:0] rd_req_addr, wr_req_addr;
    logic [TAG_W-1:0]  rd_req_tag, wr_req_tag;
    logic              dp_valid_out = 1'b0;
    logic              wr_rsp_valid = 1'b0;
`ifdef GRAYSCALE_SCHED_PERF_EN
    logic [31:0]       perf_cycles, perf_stalls;
`endif

    always #5 clk = ~clk;

    grayscale_line_scheduler #(
        .ADDR_W(ADDR_W), .LINE_CNT_W(LCW), .MAX_OUTSTANDING(MAXO), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_lines(num_lines),
        .rd_base(rd_base), .wr_base(wr_base), .busy(busy), .done(done), .err(err),
        .c0_almfull(c0_almfull), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
        .rd_req_tag(rd_req_tag), .c1_almfull(c1_almfull), .dp_valid_out(dp_valid_out),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_tag(wr_req_tag),
`ifdef GRAYSCALE_SCHED_PERF_EN
        .wr_rsp_valid(wr_rsp_valid), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`else
        .wr_rsp_valid(wr_rsp_valid)
`endif
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } req_t;

    req_t exp_rd_q[$];
    req_t exp_wr_q[$];
    int   dp_due_q[$];
    int   ack_due_q[$];
    req_t m_e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rd_seen = 0;
    int dp_sent = 0;
    int n_done = 0;
    int dp_lat = 3;
    int dp_allow = 0;
    bit dp_hold = 1'b0;
    bit af_rand = 1'b0;
    bit mon_en = 1'b0;
    bit prev_af = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a request.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_req_valid) begin
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", 64'd1, 64'd0);
                end else begin
                    m_e = exp_rd_q.pop_front();
                    check("rd_addr", 64'(rd_req_addr), 64'(m_e.addr));
                    check("rd_tag", 64'(rd_req_tag), 64'(m_e.tag));
                end
                check("rd_after_almfull", 64'(prev_af), 64'd0);
                rd_seen++;
                check("inflight_cap", 64'((rd_seen - dp_sent) <= MAXO), 64'd1);
                dp_due_q.push_back(cyc + dp_lat);
            end
            if (wr_req_valid) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    m_e = exp_wr_q.pop_front();
                    check("wr_addr", 64'(wr_req_addr), 64'(m_e.addr));
                    check("wr_tag", 64'(wr_req_tag), 64'(m_e.tag));
                end
                ack_due_q.push_back(cyc + $urandom_range(1, 6));
            end
            if (done) n_done++;
        end
        prev_af = c0_almfull | c1_almfull;
    end

    // One clock of stimulus: datapath results and acks from the models.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        dp_valid_out = 1'b0;
        if (dp_due_q.size() > 0 && dp_due_q[0] <= cyc && (!dp_hold || dp_allow > 0)) begin
            dp_valid_out = 1'b1;
            void'(dp_due_q.pop_front());
            dp_sent++;
            if (dp_hold) dp_allow--;
        end
        wr_rsp_valid = 1'b0;
        if (ack_due_q.size() > 0 && ack_due_q[0] <= cyc) begin
            wr_rsp_valid = 1'b1;
            void'(ack_due_q.pop_front());
        end
        if (af_rand) begin
            c0_almfull = ($urandom_range(0, 5) == 0);
            c1_almfull = ($urandom_range(0, 7) == 0);
        end
    endtask

    // Reference model: a job of n lines reads rb+i and writes wb+i, tag i.
    task automatic start_job(string name, int n, logic [ADDR_W-1:0] rb,
                             logic [ADDR_W-1:0] wb, int lat, bit afr);
        dp_lat  = lat;
        af_rand = afr;
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back('{addr: rb + ADDR_W'(i), tag: TAG_W'(i)});
            exp_wr_q.push_back('{addr: wb + ADDR_W'(i), tag: TAG_W'(i)});
        end
        num_lines = LCW'(n);
        rd_base   = rb;
        wr_base   = wb;
        start     = 1'b1;
        step();
        @(negedge clk);
        check({name, "_err_clear"}, 64'(err), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic finish_job(string name, int budget);
        int  d0 = n_done;
        bit  seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        af_rand = 1'b0;
        c0_almfull = 1'b0;
        c1_almfull = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check({name, "_done_pulses"}, 64'(n_done - d0), 64'd1);
        check({name, "_busy_off"}, 64'(busy), 64'd0);
        check({name, "_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
        check({name, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
        check({name, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int blocked;
        int d0;
        int zd;
        bit ok;
        logic [ADDR_W-1:0] rb, wb;

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rd_valid", 64'(rd_req_valid), 64'd0);
        check("rst_wr_valid", 64'(wr_req_valid), 64'd0);
        mon_en = 1'b1;
        step();
        reset_n = 1'b1;
        repeat (2) step();

        // Basic 4-line job.
        start_job("basic", 4, 42'h100, 42'h200, 3, 1'b0);
        finish_job("basic", 200);

        // Zero-line job: a single done pulse, no requests, never busy.
        num_lines = '0;
        start = 1'b1;
        zd = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            if (done) zd++;
            check("zero_busy", 64'(busy), 64'd0);
            check("zero_no_rd", 64'(rd_req_valid), 64'd0);
            check("zero_no_wr", 64'(wr_req_valid), 64'd0);
        end
        check("zero_done_once", 64'(zd), 64'd1);

        // Stalled datapath: the in-flight cap stops reads at 8.
        dp_hold = 1'b1;
        dp_allow = 0;
        rd_seen = 0;
        dp_sent = 0;
        start_job("stall", 20, 42'h4000, 42'h8000, 2, 1'b0);
        repeat (30) step();
        check("stall_reads", 64'(rd_seen), 64'd8);
        dp_allow = 1;
        repeat (10) step();
        check("release_one_read", 64'(rd_seen), 64'd9);
        dp_hold = 1'b0;
        finish_job("stall", 600);

        // c0 almost-full hold for 10 cycles mid-job.
        start_job("afull", 20, 42'h1000, 42'h3000, 3, 1'b0);
        repeat (5) step();
        c0_almfull = 1'b1;
        @(negedge clk);
        blocked = 0;
        for (int i = 1; i < 10; i++) begin
            step();
            @(negedge clk);
            if (rd_req_valid) blocked++;
        end
        step();
        c0_almfull = 1'b0;
        @(negedge clk);
        if (rd_req_valid) blocked++;
        check("afull_no_reads", 64'(blocked), 64'd0);
        step();
        @(negedge clk);
        check("afull_resume", 64'(rd_req_valid), 64'd1);
        finish_job("afull", 600);

        // Extra ack in IDLE sets sticky err; next start clears it.
        step();
        wr_rsp_valid = 1'b1;
        step();
        @(negedge clk);
        check("extra_ack_err", 64'(err), 64'd1);
        step();
        @(negedge clk);
        check("extra_ack_err_sticky", 64'(err), 64'd1);
        start_job("after_err", 2, 42'h50, 42'h60, 1, 1'b0);
        finish_job("after_err", 200);

        // Asynchronous reset mid-job.
        dp_hold = 1'b1;
        dp_allow = 0;
        start_job("abort", 20, 42'h700, 42'h900, 2, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            if (rd_seen >= 5) ok = 1'b1;
        end
        c0_almfull = 1'b1;
        step();
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        check("abort_rd_valid", 64'(rd_req_valid), 64'd0);
        check("abort_wr_valid", 64'(wr_req_valid), 64'd0);
        exp_rd_q.delete();
        exp_wr_q.delete();
        dp_due_q.delete();
        ack_due_q.delete();
        rd_seen = 0;
        dp_sent = 0;
        dp_hold = 1'b0;
        c0_almfull = 1'b0;
        d0 = n_done;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        start_job("post_reset", 3, 42'h20, 42'h40, 3, 1'b0);
        finish_job("post_reset", 200);

        // Randomized jobs with random almost-full, latency and ack delay.
        for (int j = 0; j < 6; j++) begin
            rb = {$urandom_range(0, 1023), $urandom()};
            wb = {$urandom_range(0, 1023), $urandom()};
            if (j == 1) rb = 42'h3FF_FFFF_FFFD;
            if (j == 2) wb = 42'h3FF_FFFF_FFFE;
            start_job("rand", int'($urandom_range(1, 40)), rb, wb,
                      int'($urandom_range(1, 8)), 1'b1);
            if (j == 3) begin
                repeat (3) step();
                num_lines = LCW'(5);
                rd_base = '0;
                start = 1'b1;
            end
            finish_job("rand", 3000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
